// File: rtl/alsu_shift_pkg.sv
// Shared definitions for the ALSU multi-cycle shift path: Sel encoding, FSM states, default width.
package alsu_shift_pkg;

    localparam int DEFAULT_WIDTH = 4;

    localparam logic [1:0] SEL_A_RIGHT = 2'b00;
    localparam logic [1:0] SEL_A_LEFT  = 2'b01;
    localparam logic [1:0] SEL_B_RIGHT = 2'b10;
    localparam logic [1:0] SEL_B_LEFT  = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/arith_shift_step.sv
// Single-position arithmetic shift of a WIDTH vector; dir=1 shifts left, dir=0 shifts right.
// ovf_step flags a left step that flips the sign bit.
import alsu_shift_pkg::*;

module arith_shift_step #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] d,
    input  logic             dir,
    output logic [WIDTH-1:0] q,
    output logic             ovf_step
);

    always_comb begin
        if (dir) begin
            q = {d[WIDTH-2:0], 1'b0};
        end else begin
            q = {d[WIDTH-1], d[WIDTH-1:1]};
        end
        ovf_step = dir & (q[WIDTH-1] ^ d[WIDTH-1]);
    end

endmodule

// File: rtl/arith_shift_seq_unit.sv
// Multi-cycle arithmetic shifter, one bit position per clock, start/busy/done handshake.
// Optional sticky left-shift overflow output enabled by ARITH_SHIFT_OVF_EN.
//
// state | meaning
// IDLE  | ready, out holds the last result
// SHIFT | shifting work one position per cycle until the counter reaches zero
// DONE  | one-cycle done pulse; ready, a start here chains straight into SHIFT
import alsu_shift_pkg::*;

module arith_shift_seq_unit #(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int SHAMT_W = $clog2(WIDTH) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [1:0]         Sel,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
`ifdef ARITH_SHIFT_OVF_EN
    output logic               ovf,
`endif
    output logic [WIDTH-1:0]   out
);

    localparam logic [SHAMT_W-1:0] WIDTH_SHAMT = SHAMT_W'(WIDTH);

    state_e             state_q;
    state_e             state_d;
    logic [WIDTH-1:0]   work_q;
    logic [SHAMT_W-1:0] cnt_q;
    logic               left_q;
    logic [WIDTH-1:0]   out_q;
    logic [WIDTH-1:0]   step_q;
    logic               ovf_step;

    logic               accept;
    logic               sel_left;
    logic [WIDTH-1:0]   operand;
    logic [SHAMT_W-1:0] shamt_clamped;

    assign accept        = start && (state_q != SHIFT);
    assign sel_left      = (Sel == SEL_A_LEFT) || (Sel == SEL_B_LEFT);
    assign operand       = ((Sel == SEL_B_RIGHT) || (Sel == SEL_B_LEFT)) ? B : A;
    assign shamt_clamped = (shamt >= WIDTH_SHAMT) ? WIDTH_SHAMT : shamt;

    arith_shift_step #(.WIDTH(WIDTH)) u_step (
        .d        (work_q),
        .dir      (left_q),
        .q        (step_q),
        .ovf_step (ovf_step)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SHIFT;
            SHIFT:   if (cnt_q == '0) state_d = DONE;
            DONE:    state_d = accept ? SHIFT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // accept and SHIFT are mutually exclusive, so the datapath has a single writer per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            left_q  <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                work_q <= operand;
                cnt_q  <= shamt_clamped;
                left_q <= sel_left;
            end else if (state_q == SHIFT) begin
                if (cnt_q != '0) begin
                    work_q <= step_q;
                    cnt_q  <= cnt_q - SHAMT_W'(1);
                end else begin
                    out_q <= work_q;
                end
            end
        end
    end

`ifdef ARITH_SHIFT_OVF_EN
    logic ovf_acc_q;
    logic ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_acc_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else if (accept) begin
            ovf_acc_q <= 1'b0;
        end else if (state_q == SHIFT) begin
            if (cnt_q != '0) begin
                ovf_acc_q <= ovf_acc_q | ovf_step;
            end else begin
                ovf_q <= ovf_acc_q;
            end
        end
    end

    assign ovf = ovf_q;
`else
    logic ovf_step_unused;
    assign ovf_step_unused = ovf_step;
`endif

    assign busy = (state_q == SHIFT);
    assign done = (state_q == DONE);
    assign out  = out_q;

endmodule
